// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory controller.
// Provides the req_type encodings, the controller FSM state type, the default
// clear-sweep value and a request-type legality helper.
package dm_pkg;

    localparam int unsigned DATA_W = 32;

    // Request type encodings; bit 2 selects zero-extension on loads.
    typedef enum logic [2:0] {
        RT_LB  = 3'b000,
        RT_LH  = 3'b001,
        RT_LW  = 3'b011,
        RT_LBU = 3'b100,
        RT_LHU = 3'b101
    } req_type_e;

    // Access size field, req_type[1:0].
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } dm_state_e;

    localparam logic [DATA_W-1:0] CLR_VAL_DEF = 32'h0000_0000;

    // True for the five defined request encodings.
    function automatic logic type_legal(input logic [2:0] t);
        logic ok;
        case (t)
            RT_LB, RT_LH, RT_LW, RT_LBU, RT_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_bytelane.sv
// Byte-lane steering for the data-memory controller (purely combinational).
// Ports:
//   size      access size (req_type[1:0])
//   uns       zero-extend loads when set (req_type[2])
//   off       byte offset within the word (addr[1:0])
//   old_word  current memory word at the addressed index
//   wdata     right-aligned store data
//   merged_c  old_word with the addressed lanes replaced by wdata
//   ldata_c   addressed lanes, right-aligned and sign/zero extended
module dm_bytelane
    import dm_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] merged_c,
    output logic [DATA_W-1:0] ldata_c
);

    logic [4:0]        shamt;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] wrep;
    logic [DATA_W-1:0] shifted;

    // Halfword accesses always start on an even lane.
    always_comb begin
        shamt     = '0;
        lane_mask = '0;
        wrep      = '0;
        case (size)
            SZ_BYTE: begin
                shamt     = {off, 3'b000};
                lane_mask = 32'h0000_00FF << shamt;
                wrep      = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                shamt     = {off[1], 4'b0000};
                lane_mask = 32'h0000_FFFF << shamt;
                wrep      = {2{wdata[15:0]}};
            end
            default: begin
                shamt     = '0;
                lane_mask = '1;
                wrep      = wdata;
            end
        endcase
    end

    // Store merge: replace only the addressed lanes.
    assign merged_c = (old_word & ~lane_mask) | (wrep & lane_mask);

    assign shifted = old_word >> shamt;

    // Load extension.
    always_comb begin
        ldata_c = '0;
        case (size)
            SZ_BYTE: ldata_c = uns ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ldata_c = uns ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
            default: ldata_c = shifted;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: 2**ADDR_W x 32-bit word store with byte/half/word
// loads and stores, a clear sweep after reset, and a one-cycle response.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_we/req_type/req_addr/req_wdata/req_pc  request
//   rsp_valid/rsp_rdata/rsp_err                                     response
//   init_busy                                                       sweep active
// Optional: define DM_TRACE_EN to print one trace line per successful store.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 10,
    parameter logic [DATA_W-1:0] CLR_VAL = CLR_VAL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [31:0]       req_pc,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    dm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q;

    logic              accept_c;
    logic              illegal_c, misalign_c, range_err_c, err_c;
    logic [ADDR_W-1:0] idx_c;
    logic [DATA_W-1:0] old_word_c, merged_c, ldata_c;
    logic              clr_we_c, store_we_c;
    logic              ready_d, busy_d;

    // Request decode.
    assign accept_c    = req_valid & req_ready;
    assign idx_c       = req_addr[ADDR_W+1:2];
    assign illegal_c   = !type_legal(req_type);
    assign misalign_c  = ((req_type[1:0] == SZ_HALF) && req_addr[0])
                       || ((req_type[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign range_err_c = (req_addr >> (ADDR_W + 2)) != 32'(0);
    assign err_c       = illegal_c | misalign_c | range_err_c;
    assign old_word_c  = mem[idx_c];

    dm_bytelane u_bytelane (
        .size     (req_type[1:0]),
        .uns      (req_type[2]),
        .off      (req_addr[1:0]),
        .old_word (old_word_c),
        .wdata    (req_wdata),
        .merged_c (merged_c),
        .ldata_c  (ldata_c)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // FSM next state: leave INIT once the last word has been cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM outputs; ready/busy follow the next state so they are registered.
    always_comb begin
        clr_we_c   = 1'b0;
        store_we_c = 1'b0;
        ready_d    = (state_d == ST_IDLE);
        busy_d     = (state_d == ST_INIT);
        case (state_q)
            ST_INIT: clr_we_c   = 1'b1;
            ST_IDLE: store_we_c = accept_c & req_we & !err_c;
            default: ;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt_q <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (clr_we_c) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            req_ready <= ready_d;
            init_busy <= busy_d;
            rsp_valid <= accept_c;
            rsp_err   <= accept_c & err_c;
            rsp_rdata <= (accept_c && !req_we && !err_c) ? ldata_c : '0;
        end
    end

    // Storage array; not reset, the sweep initialises it.
    always_ff @(posedge clk) begin
        if (clr_we_c)        mem[clr_cnt_q] <= CLR_VAL;
        else if (store_we_c) mem[idx_c]     <= merged_c;
    end

`ifdef DM_TRACE_EN
    // Store trace: time, issuing PC, word-aligned address, merged word.
    always @(posedge clk) begin
        if (reset && store_we_c)
            $display("%0t@%h: *%h <= %h", $time, req_pc,
                     {req_addr[31:2], 2'b00}, merged_c);
    end
`else
    logic [31:0] unused_pc;
    assign unused_pc = req_pc;
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed self-checking bench for dm_ctrl with ADDR_W=4 (16 words).
module tb_dm_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    int checks   = 0;
    int failures = 0;
    int busy_cycles;

    dm_ctrl #(.ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; return at the negedge after acceptance,
    // when the response for it is on the outputs.
    task automatic issue(input logic we, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = typ;
        req_addr  = addr;
        req_wdata = wd;
        req_pc    = 32'h0000_1000 + addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] data, input logic err);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_err"},   32'(rsp_err),   32'(err));
        chk({tag, "_rdata"}, rsp_rdata,      data);
    endtask

    // Count cycles with init_busy high (sampled before each edge), bounded.
    task automatic count_sweep(input string tag);
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (!init_busy) break;
            busy_cycles++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
        chk({tag, "_ready"},       32'(req_ready),   32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_type  = 3'b011;
        req_addr  = '0;
        req_wdata = '0;
        req_pc    = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",  32'(init_busy), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);
        chk("rst_rdata", rsp_rdata,      32'h0);

        // Clear sweep takes exactly 16 cycles
        reset = 1'b1;
        count_sweep("sweep1");

        issue(1'b0, 3'b011, 32'h3C, 32'h0);
        chk_rsp("lw_3c", 32'h0, 1'b0);
        @(negedge clk);
        chk("idle_valid", 32'(rsp_valid), 32'd0);

        // Byte store merges into an existing word
        issue(1'b1, 3'b011, 32'h10, 32'h1122_3344);
        chk_rsp("sw_10", 32'h0, 1'b0);
        issue(1'b1, 3'b000, 32'h12, 32'h0000_00AA);
        chk_rsp("sb_12", 32'h0, 1'b0);
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        chk_rsp("lw_10", 32'h11AA_3344, 1'b0);

        // Load extension
        issue(1'b1, 3'b011, 32'h20, 32'h80FF_7F01);
        issue(1'b0, 3'b000, 32'h22, 32'h0);
        chk_rsp("lb_22", 32'hFFFF_FFFF, 1'b0);
        issue(1'b0, 3'b100, 32'h22, 32'h0);
        chk_rsp("lbu_22", 32'h0000_00FF, 1'b0);
        issue(1'b0, 3'b001, 32'h22, 32'h0);
        chk_rsp("lh_22", 32'hFFFF_80FF, 1'b0);
        issue(1'b0, 3'b101, 32'h20, 32'h0);
        chk_rsp("lhu_20", 32'h0000_7F01, 1'b0);
        issue(1'b0, 3'b000, 32'h21, 32'h0);
        chk_rsp("lb_21", 32'h0000_007F, 1'b0);

        // Error cases leave memory untouched
        issue(1'b1, 3'b001, 32'h21, 32'h0000_5555);
        chk_rsp("sh_21_misal", 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h22, 32'h0);
        chk_rsp("lw_22_misal", 32'h0, 1'b1);
        issue(1'b0, 3'b111, 32'h20, 32'h0);
        chk_rsp("type111_ld", 32'h0, 1'b1);
        issue(1'b1, 3'b111, 32'h20, 32'h1234_5678);
        chk_rsp("type111_st", 32'h0, 1'b1);
        issue(1'b1, 3'b010, 32'h20, 32'h1234_5678);
        chk_rsp("type010_st", 32'h0, 1'b1);
        issue(1'b0, 3'b110, 32'h20, 32'h0);
        chk_rsp("type110_ld", 32'h0, 1'b1);
        issue(1'b1, 3'b011, 32'h60, 32'h1234_5678);
        chk_rsp("oor_st_60", 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h8000_0020, 32'h0);
        chk_rsp("oor_ld_hi", 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h20, 32'h0);
        chk_rsp("lw_20_unchanged", 32'h80FF_7F01, 1'b0);

        // Store type with bit 2 set is still a byte store
        issue(1'b1, 3'b100, 32'h23, 32'h0000_0012);
        issue(1'b0, 3'b101, 32'h22, 32'h0);
        chk_rsp("lhu_22_after_sbu", 32'h0000_12FF, 1'b0);

        // Halfword store to upper lanes
        issue(1'b1, 3'b001, 32'h12, 32'h0000_BEEF);
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        chk_rsp("lw_10_after_sh", 32'hBEEF_3344, 1'b0);

        // Back-to-back store then load, reset during the load's response
        issue(1'b1, 3'b011, 32'h08, 32'hDEAD_BEEF);
        chk_rsp("sw_08", 32'h0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_type  = 3'b011;
        req_addr  = 32'h08;
        @(posedge clk);
        #1;
        chk_rsp("lw_08_b2b", 32'hDEAD_BEEF, 1'b0);
        #1 reset = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rdata", rsp_rdata,      32'h0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_busy",  32'(init_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        count_sweep("sweep2");

        issue(1'b0, 3'b011, 32'h08, 32'h0);
        chk_rsp("lw_08_cleared", 32'h0, 1'b0);
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        chk_rsp("lw_10_cleared", 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
